// File: rtl/data_accumulator.sv
// Triggered waveform-averaging accumulator: sums NUM_CAPTURES windows of
// RECORD_LEN 8-bit samples point-by-point into an 18-bit memory, then offers
// the summed record to a downstream reader one word per read strobe.
//
// Read handshake: a word is transferred on any rising clk edge where
// dataReadyToRead=1 and dataRead=1. dataOut is valid whenever dataReadyToRead
// is high (first-word-fall-through). dataRead with dataReadyToRead=0 has no
// effect. Once high, dataReadyToRead stays high until the last word of the
// record has been transferred.
module data_accumulator #(
    parameter int RECORD_LEN   = 64,
    parameter int NUM_CAPTURES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  inputData,
    input  logic        dataCaptureStrobe,
    input  logic        dataRead,
    output logic        dataReadyToRead,
    output logic        dataEmpty,
    output logic [17:0] dataOut,
    output logic [2:0]  debugState
);

    localparam int IW = (RECORD_LEN > 1) ? $clog2(RECORD_LEN) : 1;
    localparam int CW = $clog2(NUM_CAPTURES + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARMED   = 3'd1,
        CAPTURE = 3'd2,
        DRAIN   = 3'd3,
        READOUT = 3'd4
    } state_t;

    state_t state;
    state_t nextState;

    logic [17:0]   mem [RECORD_LEN];
    logic [IW-1:0] sampleIdx;
    logic [IW-1:0] readIdx;
    logic [CW-1:0] captureCount;
    logic          strobePrev;

    logic strobeRise;
    logic lastSample;
    logic lastCapture;
    logic lastWord;
    logic consume;

    // A capture is armed only by a rising strobe, so a long strobe counts once
    assign strobeRise  = dataCaptureStrobe & ~strobePrev;
    assign lastSample  = (sampleIdx == IW'(RECORD_LEN - 1));
    assign lastCapture = (captureCount == CW'(NUM_CAPTURES - 1));
    assign lastWord    = (readIdx == IW'(RECORD_LEN - 1));
    assign consume     = dataRead & dataReadyToRead;
    assign debugState  = state;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state decode; strobes outside IDLE/ARMED are simply not looked at
    always_comb begin
        nextState = state;
        case (state)
            IDLE, ARMED: begin
                if (strobeRise) begin
                    nextState = CAPTURE;
                end
            end
            CAPTURE: begin
                if (lastSample) begin
                    nextState = lastCapture ? DRAIN : ARMED;
                end
            end
            DRAIN: begin
                nextState = READOUT;
            end
            READOUT: begin
                if (consume && lastWord) begin
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // Accumulation memory: the first capture overwrites, later ones add.
    // Each address is touched once per capture, so the same-cycle
    // read-modify-write has no hazard and needs no forwarding.
    always_ff @(posedge clk) begin
        if (!rst && state == CAPTURE) begin
            mem[sampleIdx] <= ((captureCount == '0) ? 18'd0 : mem[sampleIdx])
                              + {10'd0, inputData};
        end
    end

    // Counters, strobe history and the registered read port
    always_ff @(posedge clk) begin
        if (rst) begin
            sampleIdx       <= '0;
            readIdx         <= '0;
            captureCount    <= '0;
            strobePrev      <= 1'b0;
            dataReadyToRead <= 1'b0;
            dataEmpty       <= 1'b1;
            dataOut         <= 18'd0;
        end else begin
            strobePrev <= dataCaptureStrobe;
            case (state)
                CAPTURE: begin
                    // RECORD_LEN is a power of two, so the index wraps to 0
                    sampleIdx <= sampleIdx + IW'(1);
                    if (lastSample) begin
                        captureCount <= captureCount + CW'(1);
                    end
                end
                DRAIN: begin
                    readIdx         <= '0;
                    dataOut         <= mem[0];
                    dataReadyToRead <= 1'b1;
                    dataEmpty       <= 1'b0;
                end
                READOUT: begin
                    if (consume) begin
                        if (lastWord) begin
                            dataReadyToRead <= 1'b0;
                            dataEmpty       <= 1'b1;
                            captureCount    <= '0;
                        end else begin
                            readIdx <= readIdx + IW'(1);
                            dataOut <= mem[readIdx + IW'(1)];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_data_accumulator.sv
// Bench for data_accumulator: a main 64x4 instance driven from a table of
// scenarios, plus a 4x1024 saturation instance and an 8x1 single-capture one.
module tb_data_accumulator;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Main instance (RECORD_LEN=64, NUM_CAPTURES=4)
    logic [7:0]  inputData = '0;
    logic        dataCaptureStrobe = 1'b0;
    logic        dataRead = 1'b0;
    logic        dataReadyToRead;
    logic        dataEmpty;
    logic [17:0] dataOut;
    logic [2:0]  debugState;

    // Saturation instance (RECORD_LEN=4, NUM_CAPTURES=1024)
    logic [7:0]  sData = '0;
    logic        sStrobe = 1'b0;
    logic        sRead = 1'b0;
    logic        sReady;
    logic        sEmpty;
    logic [17:0] sOut;
    logic [2:0]  sState;

    // Single-capture instance (RECORD_LEN=8, NUM_CAPTURES=1)
    logic [7:0]  oData = '0;
    logic        oStrobe = 1'b0;
    logic        oRead = 1'b0;
    logic        oReady;
    logic        oEmpty;
    logic [17:0] oOut;
    logic [2:0]  oState;

    data_accumulator #(.RECORD_LEN(64), .NUM_CAPTURES(4)) dut (
        .clk(clk), .rst(rst), .inputData(inputData),
        .dataCaptureStrobe(dataCaptureStrobe), .dataRead(dataRead),
        .dataReadyToRead(dataReadyToRead), .dataEmpty(dataEmpty),
        .dataOut(dataOut), .debugState(debugState)
    );

    data_accumulator #(.RECORD_LEN(4), .NUM_CAPTURES(1024)) dutSat (
        .clk(clk), .rst(rst), .inputData(sData),
        .dataCaptureStrobe(sStrobe), .dataRead(sRead),
        .dataReadyToRead(sReady), .dataEmpty(sEmpty),
        .dataOut(sOut), .debugState(sState)
    );

    data_accumulator #(.RECORD_LEN(8), .NUM_CAPTURES(1)) dutOne (
        .clk(clk), .rst(rst), .inputData(oData),
        .dataCaptureStrobe(oStrobe), .dataRead(oRead),
        .dataReadyToRead(oReady), .dataEmpty(oEmpty),
        .dataOut(oOut), .debugState(oState)
    );

    // ---------------- scoreboard ----------------
    int compared   = 0;
    int mismatched = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected accumulated word k for a ramp sample(i) = (i*mul+off) mod 256
    function automatic logic [31:0] expWord(input int mul, input int off, input int k);
        return 32'(4 * ((k * mul + off) & 255));
    endfunction

    // ---------------- driver tasks ----------------
    // One capture window on the main instance; the strobe edge is followed by
    // 64 sample edges. strobeLen counts edges the strobe stays high.
    task automatic doCapture(input int mul, input int off, input int strobeLen, input bit noise);
        dataCaptureStrobe = 1'b1;
        tick();
        for (int i = 0; i < 64; i++) begin
            dataCaptureStrobe = (i < strobeLen - 1) || (noise && (i == 20 || i == 45));
            inputData = 8'(i * mul + off);
            tick();
        end
        dataCaptureStrobe = 1'b0;
    endtask

    task automatic idleGap(input int n, input int seed);
        for (int j = 0; j < n; j++) begin
            inputData = 8'(j * 53 + seed);
            tick();
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int mul;
        int off;
        int strobeLen;
        bit noise;
        bit throttle;
        bit abortFirst;
        int expFirst;
        int expLast;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int lat;
        int k;
        int cyc;
        bit phase;
        bit rd;

        vecs[0] = '{mul: 1, off: 0,   strobeLen: 1, noise: 0, throttle: 0, abortFirst: 0, expFirst: 0,   expLast: 252};
        vecs[1] = '{mul: 1, off: 0,   strobeLen: 1, noise: 0, throttle: 1, abortFirst: 0, expFirst: 0,   expLast: 252};
        vecs[2] = '{mul: 1, off: 0,   strobeLen: 1, noise: 1, throttle: 0, abortFirst: 0, expFirst: 0,   expLast: 252};
        vecs[3] = '{mul: 3, off: 7,   strobeLen: 5, noise: 0, throttle: 0, abortFirst: 0, expFirst: 28,  expLast: 784};
        vecs[4] = '{mul: 1, off: 0,   strobeLen: 1, noise: 0, throttle: 0, abortFirst: 1, expFirst: 0,   expLast: 252};
        vecs[5] = '{mul: 5, off: 100, strobeLen: 1, noise: 1, throttle: 1, abortFirst: 0, expFirst: 400, expLast: 636};

        // ---- reset ----
        rst = 1'b1;
        tick();
        check("reset_ready", 32'(dataReadyToRead), 0);
        check("reset_empty", 32'(dataEmpty), 1);
        check("reset_out", 32'(dataOut), 0);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            inputData = 8'(i * 37 + 11);
            dataRead  = i[0];
            tick();
        end
        dataRead = 1'b0;
        check("nostrobe_ready", 32'(dataReadyToRead), 0);
        check("nostrobe_empty", 32'(dataEmpty), 1);
        check("nostrobe_out", 32'(dataOut), 0);

        // ---- table-driven runs on the main instance ----
        for (int s = 0; s < 6; s++) begin
            if (vecs[s].abortFirst) begin
                doCapture(5, 3, 1, 1'b0);
                idleGap(40, s);
                doCapture(5, 3, 1, 1'b0);
                idleGap(40, s);
                dataCaptureStrobe = 1'b1;
                tick();
                dataCaptureStrobe = 1'b0;
                for (int i = 0; i < 30; i++) begin
                    inputData = 8'(200 + i);
                    tick();
                end
                rst = 1'b1;
                tick();
                rst = 1'b0;
                check($sformatf("sc%0d_abort_ready", s), 32'(dataReadyToRead), 0);
                check($sformatf("sc%0d_abort_empty", s), 32'(dataEmpty), 1);
                idleGap(5, s);
            end

            for (int c = 0; c < 4; c++) begin
                doCapture(vecs[s].mul, vecs[s].off, vecs[s].strobeLen, vecs[s].noise);
                if (c < 3) begin
                    check($sformatf("sc%0d_cap%0d_empty", s, c), 32'(dataEmpty), 1);
                    idleGap(40, s + c);
                end
            end

            // ready must appear within 3 edges of the edge that took the last sample
            lat = 0;
            while (!dataReadyToRead && lat < 10) begin
                tick();
                lat++;
            end
            check($sformatf("sc%0d_ready_latency_le3(lat=%0d)", s, lat), 32'(lat >= 1 && lat <= 3), 1);
            check($sformatf("sc%0d_empty_at_ready", s), 32'(dataEmpty), 0);

            k = 0;
            cyc = 0;
            phase = 1'b0;
            while (k < 64 && cyc < 400) begin
                rd = vecs[s].throttle ? phase : 1'b1;
                phase = ~phase;
                dataRead = rd;
                dataCaptureStrobe = vecs[s].noise && (cyc == 10);
                if (rd && dataReadyToRead) begin
                    if (k == 0)
                        check($sformatf("sc%0d_word0", s), 32'(dataOut), 32'(vecs[s].expFirst));
                    else if (k == 63)
                        check($sformatf("sc%0d_word63", s), 32'(dataOut), 32'(vecs[s].expLast));
                    else
                        check($sformatf("sc%0d_word%0d", s, k), 32'(dataOut), expWord(vecs[s].mul, vecs[s].off, k));
                    k++;
                end
                tick();
                cyc++;
            end
            dataCaptureStrobe = 1'b0;
            check($sformatf("sc%0d_words_read", s), 32'(k), 64);
            check($sformatf("sc%0d_read_cycles", s), 32'(cyc), vecs[s].throttle ? 128 : 64);
            check($sformatf("sc%0d_done_ready", s), 32'(dataReadyToRead), 0);
            check($sformatf("sc%0d_done_empty", s), 32'(dataEmpty), 1);

            // a read held past the end of the record is ignored
            dataRead = 1'b1;
            tick();
            check($sformatf("sc%0d_extra_read_ready", s), 32'(dataReadyToRead), 0);
            check($sformatf("sc%0d_extra_read_empty", s), 32'(dataEmpty), 1);
            check($sformatf("sc%0d_out_hold", s), 32'(dataOut), 32'(vecs[s].expLast));
            dataRead = 1'b0;
            idleGap(5, s);
        end

        // ---- saturation: 1024 captures of 255 into 4 words ----
        sData = 8'd255;
        for (int c = 0; c < 1024; c++) begin
            sStrobe = 1'b1;
            tick();
            sStrobe = 1'b0;
            repeat (5) tick();
        end
        lat = 0;
        while (!sReady && lat < 10) begin
            tick();
            lat++;
        end
        check("sat_ready", 32'(sReady), 1);
        sRead = 1'b1;
        k = 0;
        cyc = 0;
        while (k < 4 && cyc < 20) begin
            if (sReady) begin
                check($sformatf("sat_word%0d", k), 32'(sOut), 32'h3FC00);
                k++;
            end
            tick();
            cyc++;
        end
        sRead = 1'b0;
        check("sat_words_read", 32'(k), 4);
        check("sat_done_empty", 32'(sEmpty), 1);

        // ---- single capture: every word equals the sample ----
        oData = 8'd255;
        oStrobe = 1'b1;
        tick();
        oStrobe = 1'b0;
        repeat (8) tick();
        lat = 0;
        while (!oReady && lat < 10) begin
            tick();
            lat++;
        end
        check($sformatf("one_ready_latency_le3(lat=%0d)", lat), 32'(lat >= 1 && lat <= 3), 1);
        oRead = 1'b1;
        k = 0;
        cyc = 0;
        while (k < 8 && cyc < 30) begin
            if (oReady) begin
                check($sformatf("one_word%0d", k), 32'(oOut), 255);
                k++;
            end
            tick();
            cyc++;
        end
        oRead = 1'b0;
        check("one_words_read", 32'(k), 8);
        check("one_done_empty", 32'(oEmpty), 1);

        // ---- final report ----
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // Global time bound
    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d mismatched %0d", compared, mismatched);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/data_accumulator.md
Name: data_accumulator

Overview:
Triggered waveform-averaging accumulator for the acquisition datapath. On each capture strobe it records a fixed-length window of 8-bit ADC samples and adds it point-by-point into an 18-bit accumulation memory. After a programmed number of captures, the summed record is offered to a downstream reader one word per read strobe.

Parameters:
RECORD_LEN, 64, samples per capture window and accumulation memory depth (power of two, 2..1024).
NUM_CAPTURES, 4, captures summed before readout (1..1024; this range guarantees no 18-bit overflow).

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  synchronous, active-high reset.
inputData  input  8  unsigned sample, valid every clk.
dataCaptureStrobe  input  1  capture trigger, sampled on clk.
dataRead  input  1  read/advance request from downstream.
dataReadyToRead  output  1  high while an unread accumulated word is presented on dataOut.
dataEmpty  output  1  high when no readable words remain.
dataOut  output  18  current accumulated word, first-word-fall-through.

Behaviour:
- Interface: one clock; reset is synchronous and active-high. All logic is clocked by clk only; there is no second clock.
- Reset values: dataReadyToRead=0, dataEmpty=1, dataOut=0, state=IDLE, capture count=0, sample index=0, read index=0. Reset mid-operation aborts everything. Memory contents need not be cleared.
- States: IDLE -> ARMED -> CAPTURE -> (ARMED | DRAIN) -> READOUT -> IDLE.
- IDLE/ARMED:
  - Wait for dataCaptureStrobe=1 at an edge.
  - If the strobe is high for several cycles, only the first high edge counts.
- CAPTURE:
  - Starts on the first edge after the strobe edge.
  - Sample i (i=0..RECORD_LEN-1) is inputData at the (i+1)th edge after the strobe edge.
  - For capture 0, mem[i] = zero-extended sample.
  - For later captures, mem[i] = mem[i] + sample, modulo 2^18.
  - The read-modify-write may be pipelined, but a full record must be accepted at one sample per clk with no gaps.
  - Strobes during CAPTURE, DRAIN or READOUT are ignored (not queued).
- After sample RECORD_LEN-1:
  - Capture count increments.
  - If count < NUM_CAPTURES, return to ARMED.
  - Otherwise go to DRAIN, flushing the write pipeline.
- DRAIN -> READOUT: dataReadyToRead rises at most 3 cycles after the edge that took the last sample. At the same edge dataEmpty falls and dataOut = mem[0].
- READOUT:
  - An edge with dataRead=1 and dataReadyToRead=1 consumes the current word.
  - The next word (mem[idx+1]) appears on dataOut within 1 cycle. Sustained dataRead gives one word per clk with dataReadyToRead held high.
  - dataRead while dataReadyToRead=0 is ignored.
  - When the word at index RECORD_LEN-1 is consumed: dataReadyToRead=0, dataEmpty=1 on the following edge; capture count clears; state returns to IDLE ready for a new accumulation run.
- dataEmpty is 1 in IDLE, ARMED, CAPTURE and DRAIN.
- dataOut holds its last value when not ready.
- Arithmetic is unsigned. With NUM_CAPTURES ≤ 1024 the maximum sum is 255×1024 = 261120 < 2^18.

Test Plan:
- Reset: assert rst 1 cycle -> dataReadyToRead=0, dataEmpty=1, dataOut=0; inputs toggling with no strobe leave outputs unchanged.
- Single run (RECORD_LEN=64, NUM_CAPTURES=4):
  - Stimulus: strobe 1 cycle, then ramp 0,1,2... each capture; four strobes ≥100 cycles apart; dataRead tied high after ready.
  - Required: 64 words 4·i (word0=0, word1=4, word63=252).
  - Required: ready asserted ≤3 cycles after last sample; empty=1 after word63.
- Read throttling: dataRead toggling 1-on/1-off -> each word exactly once, in order, no duplicates or skips. dataRead held high one cycle after ready falls -> ignored, dataEmpty stays 1.
- Saturating data:
  - NUM_CAPTURES=1024 with inputData=255 constant -> every word = 261120 (0x3FC00).
  - NUM_CAPTURES=1 -> every word = 255.
- Ignored strobes: strobe pulses mid-capture and during readout -> no restart, results identical to the clean run. A strobe held 5 cycles -> one capture only.
- Reset mid-capture: rst during the 3rd capture, then a full clean run -> results equal a fresh run (4·i), with no leftover partial sums.
